branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-stage consumer of the branch comparator's `beq`/`blt` results.
- Drives the comparator's `un` select from funct3.
- Resolves conditional branches, JAL and JALR into a taken flag and a target PC.
- Owns a 2-bit saturating branch history table (BHT). Fetch queries the BHT; the resolver updates it and flags mispredicts so the pipeline can redirect and flush.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_IDX_W, 4, BHT index width; table has 2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  resolver can accept.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1  in  XLEN  rs1 value (JALR base).
- in_funct3  in  3  branch condition.
- in_is_branch  in  1  conditional branch.
- in_is_jal  in  1  JAL.
- in_is_jalr  in  1  JALR.
- in_pred_taken  in  1  prediction fetch made for this PC.
- cmp_un  out  1  to comparator: unsigned compare.
- cmp_beq  in  1  from comparator: rs1 == rs2.
- cmp_blt  in  1  from comparator: rs1 < rs2.
- out_valid  out  1  resolved result held.
- out_ready  in  1  downstream accepts.
- out_taken  out  1  control transfer taken.
- out_target  out  XLEN  next PC (taken target or pc+4).
- out_mispredict  out  1  redirect/flush required.
- out_illegal  out  1  funct3 010/011 on a branch.
- flush  in  1  squash held result.
- pred_pc  in  XLEN  fetch lookup PC.
- pred_taken  out  1  BHT counter MSB for pred_pc (combinational).
- br_count  out  CNT_W  resolved control transfers.
- mp_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_taken=0, out_target=0, out_mispredict=0, out_illegal=0, br_count=0, mp_count=0, all BHT entries=2'b01 (weakly not-taken).
- cmp_un = in_funct3[1], combinational. Comparator results are sampled in the same cycle as the accept.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready.
  - Accept of an instruction with none of in_is_branch/jal/jalr set: consumed, no output produced.
- Output register state machine, EMPTY/FULL:
  - EMPTY -> FULL on accept of a control instruction.
  - FULL -> EMPTY on out_ready without a new accept.
  - FULL -> FULL on simultaneous drain and accept (back-to-back, throughput 1/cycle).
- Latency: 1 cycle from accept to out_valid.
- Condition decode:
  - 000 taken=beq; 001 taken=!beq.
  - 100 and 110 taken=blt; 101 and 111 taken=!blt.
  - 010/011: taken=0, out_illegal=1, no BHT update.
- JAL/JALR: always taken.
- Targets:
  - Branch/JAL target = in_pc + in_imm.
  - JALR target = (in_rs1 + in_imm) & ~1.
  - Not taken: target = in_pc + 4.
  - All arithmetic mod 2^XLEN (wraps).
- Mispredict = taken != in_pred_taken. Covers JAL/JALR predicted not-taken and a JALR taken whose prediction was a branch.
- BHT update on branch accept only:
  - Taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - A lookup of the same index in the same cycle returns the pre-update value.
- br_count increments per control-instruction accept; mp_count per mispredict accept. Both wrap at 2^CNT_W.
- flush:
  - Clears out_valid next edge and blocks any same-cycle accept (in_ready=0 while flush=1).
  - Counters and BHT updates already performed are kept.
- out_* hold stable while out_valid && !out_ready.

Decomposition:
- Shared package: funct3 encodings (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU), BHT reset value 2'b01, and the saturating-counter increment/decrement function.
- Sub-module: branch_history_table (2-bit counter array, one read port, one write port).

Test Plan:
- BEQ, pc=0x100, imm=0x20, beq=1, pred=0 -> next cycle out_valid=1, taken=1, target=0x120, mispredict=1, mp_count=1.
- BLTU funct3=110 -> cmp_un=1. Same cycle blt=0, pred=0 -> taken=0, target=0x104 for pc=0x100, mispredict=0.
- JALR rs1=0x2003, imm=0x4 -> target=0x2006 (LSB cleared), taken=1. No BHT change at the JALR index.
- Four BNE accepts at pc=0x40 with beq=0 -> pred_taken for pred_pc=0x40 reads 0 (initial), then 1, 1, 1; counter saturates at 3.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs held. Release -> back-to-back accept, br_count increments each cycle.
- rst asserted mid-FULL with flush=0 -> out_valid=0 and counters=0 immediately. funct3=010 after reset -> out_illegal=1, taken=0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: funct3 encodings, BHT reset value,
// FSM state type, result flag bundle and the 2-bit saturating counter update.
package branch_resolver_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken.
  localparam logic [1:0] BHT_RST = 2'b01;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } res_flags_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Decode/comparator/fetch/downstream signal bundle of the branch resolver.
// master = environment side, slave = resolver side.
interface branch_resolver_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_rs1;
  logic [2:0]       in_funct3;
  logic             in_is_branch;
  logic             in_is_jal;
  logic             in_is_jalr;
  logic             in_pred_taken;

  logic             cmp_un;
  logic             cmp_beq;
  logic             cmp_blt;

  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic             out_mispredict;
  logic             out_illegal;

  logic             flush;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_funct3,
           in_is_branch, in_is_jal, in_is_jalr, in_pred_taken,
           cmp_beq, cmp_blt, out_ready, flush, pred_pc,
    input  in_ready, cmp_un, out_valid, out_taken, out_target,
           out_mispredict, out_illegal, pred_taken, br_count, mp_count
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_funct3,
           in_is_branch, in_is_jal, in_is_jalr, in_pred_taken,
           cmp_beq, cmp_blt, out_ready, flush, pred_pc,
    output in_ready, cmp_un, out_valid, out_taken, out_target,
           out_mispredict, out_illegal, pred_taken, br_count, mp_count
  );

endinterface

// File: rtl/branch_resolver_bht.sv
// Branch history table: array of 2-bit saturating counters, one async read port, one write port.
// Read is combinational, write lands on the clock edge, so a same-cycle read sees the old value.
module branch_history_table
  import branch_resolver_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] cnt [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt[i] <= BHT_RST;
      end
    end else if (wr_en) begin
      cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/branch_resolver.sv
// Resolves branches/JAL/JALR into taken + target, flags mispredicts, trains the BHT.
// One-entry output register: 1-cycle latency, in_ready = !flush && (!out_valid || out_ready).
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  branch_resolver_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             in_rdy;
  logic             accept;
  logic             load;

  logic             is_jump;
  logic             is_cond;
  logic             is_ctrl;
  logic             cond_taken;
  logic             f3_illegal;
  res_flags_t       res;
  logic [XLEN-1:0]  sum_pc_imm;
  logic [XLEN-1:0]  sum_rs1_imm;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  res_target;

  res_flags_t       out_flags;
  logic [XLEN-1:0]  out_target_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mp_cnt_q;

  logic [1:0]       bht_rd_cnt;
  logic             bht_wr_en;
  logic             unused_pred_pc;

  // Comparator runs signed or unsigned depending on funct3 bit 1 (BLTU/BGEU).
  assign bus.cmp_un = bus.in_funct3[1];

  assign is_jump = bus.in_is_jal || bus.in_is_jalr;
  assign is_cond = bus.in_is_branch && !is_jump;
  assign is_ctrl = bus.in_is_branch || is_jump;

  always_comb begin
    cond_taken = 1'b0;
    f3_illegal = 1'b0;
    case (bus.in_funct3)
      F3_BEQ:           cond_taken = bus.cmp_beq;
      F3_BNE:           cond_taken = !bus.cmp_beq;
      F3_BLT, F3_BLTU:  cond_taken = bus.cmp_blt;
      F3_BGE, F3_BGEU:  cond_taken = !bus.cmp_blt;
      default:          f3_illegal = 1'b1;
    endcase
  end

  assign sum_pc_imm  = bus.in_pc + bus.in_imm;
  assign sum_rs1_imm = bus.in_rs1 + bus.in_imm;
  assign pc_plus4    = bus.in_pc + XLEN'(4);

  always_comb begin
    res            = '0;
    res.taken      = is_jump || (is_cond && cond_taken);
    res.illegal    = is_cond && f3_illegal;
    res.mispredict = res.taken != bus.in_pred_taken;
    if (bus.in_is_jalr) begin
      res_target = {sum_rs1_imm[XLEN-1:1], 1'b0};
    end else if (res.taken) begin
      res_target = sum_pc_imm;
    end else begin
      res_target = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // flush takes priority over both drain and accept; non-control accepts produce no output.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_EMPTY: begin
        in_rdy = !bus.flush;
        accept = bus.in_valid && in_rdy;
        if (accept && is_ctrl) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        in_rdy = !bus.flush && bus.out_ready;
        accept = bus.in_valid && in_rdy;
        if (bus.flush) begin
          state_nxt = ST_EMPTY;
        end else if (accept && is_ctrl) begin
          load      = 1'b1;
          state_nxt = ST_FULL;
        end else if (bus.out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flags    <= '0;
      out_target_q <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else if (load) begin
      out_flags    <= res;
      out_target_q <= res_target;
      br_cnt_q     <= br_cnt_q + CNT_W'(1);
      if (res.mispredict) begin
        mp_cnt_q <= mp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready       = in_rdy;
  assign bus.out_valid      = (state == ST_FULL);
  assign bus.out_taken      = out_flags.taken;
  assign bus.out_mispredict = out_flags.mispredict;
  assign bus.out_illegal    = out_flags.illegal;
  assign bus.out_target     = out_target_q;
  assign bus.br_count       = br_cnt_q;
  assign bus.mp_count       = mp_cnt_q;

  // Only legal conditional branches train the predictor.
  assign bht_wr_en = load && is_cond && !f3_illegal;

  branch_history_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.pred_pc[BHT_IDX_W+1:2]),
    .rd_cnt   (bht_rd_cnt),
    .wr_en    (bht_wr_en),
    .wr_idx   (bus.in_pc[BHT_IDX_W+1:2]),
    .wr_taken (cond_taken)
  );

  assign bus.pred_taken = bht_rd_cnt[1];

  assign unused_pred_pc = ^{bus.pred_pc[XLEN-1:BHT_IDX_W+2], bus.pred_pc[1:0], bht_rd_cnt[0]};

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized + directed bench for branch_resolver: driver feeds a reference model and
// a scoreboard queue; an independent monitor compares whatever the DUT presents.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        mp;
    logic        ill;
    logic [15:0] brc;
    logic [15:0] mpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.XLEN(32), .CNT_W(16)) bus ();

  branch_resolver #(
    .XLEN      (32),
    .BHT_IDX_W (4),
    .CNT_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        q[$];
  int          bht_m[16];
  bit          full_m;
  logic [15:0] brc_m;
  logic [15:0] mpc_m;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition: bit 2 picks less-than vs equal, bit 0 inverts the sense.
  function automatic bit ref_cond(input bit [2:0] f3, input bit beq, input bit blt);
    return (f3[2] ? blt : beq) ^ f3[0];
  endfunction

  task automatic model_reset();
    q.delete();
    full_m = 1'b0;
    brc_m  = '0;
    mpc_m  = '0;
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
  endtask

  task automatic drive(input bit v, input bit [31:0] pc, input bit [31:0] imm, input bit [31:0] rs1,
                       input bit [2:0] f3, input bit br, input bit jal, input bit jalr,
                       input bit pred, input bit beq, input bit blt, input bit ordy,
                       input bit fl, input bit [31:0] ppc);
    bit   exp_rdy, acc, cond, legal, tk;
    int   idx;
    exp_t e;
    @(negedge clk);
    bus.in_valid      = v;
    bus.in_pc         = pc;
    bus.in_imm        = imm;
    bus.in_rs1        = rs1;
    bus.in_funct3     = f3;
    bus.in_is_branch  = br;
    bus.in_is_jal     = jal;
    bus.in_is_jalr    = jalr;
    bus.in_pred_taken = pred;
    bus.cmp_beq       = beq;
    bus.cmp_blt       = blt;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    bus.pred_pc       = ppc;
    #1;
    exp_rdy = !fl && (!full_m || ordy);
    chk1("in_ready", bus.in_ready, exp_rdy);
    chk1("cmp_un", bus.cmp_un, f3 == F3_BLTU || f3 == F3_BGEU || f3 == 3'b010 || f3 == 3'b011);
    chk1("pred_taken", bus.pred_taken, bht_m[ppc[5:2]] >= 2);
    acc = v && exp_rdy;
    if (acc && (br || jal || jalr)) begin
      cond     = br && !jal && !jalr;
      legal    = (f3 != 3'b010) && (f3 != 3'b011);
      tk       = (jal || jalr) ? 1'b1 : (legal && ref_cond(f3, beq, blt));
      e.taken  = tk;
      e.target = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (tk ? pc + imm : pc + 32'd4);
      e.ill    = cond && !legal;
      e.mp     = (tk != pred);
      brc_m    = brc_m + 16'd1;
      if (e.mp) mpc_m = mpc_m + 16'd1;
      e.brc    = brc_m;
      e.mpc    = mpc_m;
      q.push_back(e);
      if (cond && legal) begin
        idx = int'(pc[5:2]);
        bht_m[idx] = tk ? ((bht_m[idx] == 3) ? 3 : bht_m[idx] + 1)
                        : ((bht_m[idx] == 0) ? 0 : bht_m[idx] - 1);
      end
      full_m = 1'b1;
    end else if (fl || ordy) begin
      full_m = 1'b0;
    end
  endtask

  task automatic idle(input bit ordy);
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, ordy, 0, 0);
  endtask

  // Monitor: every cycle with a held result, compare it with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 with no pending result at %0t", $time);
        end else begin
          e = q[0];
          chk1("out_taken", bus.out_taken, e.taken);
          chk32("out_target", bus.out_target, e.target);
          chk1("out_mispredict", bus.out_mispredict, e.mp);
          chk1("out_illegal", bus.out_illegal, e.ill);
          chk32("br_count", {16'b0, bus.br_count}, {16'b0, e.brc});
          chk32("mp_count", {16'b0, bus.mp_count}, {16'b0, e.mpc});
          if (bus.out_ready || bus.flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit          v, br, jal, jalr, ordy, fl;
    int          kind;
    bit [31:0]   pc;
    bit [31:0]   ppc;
    bus.in_valid = 0; bus.in_pc = 0; bus.in_imm = 0; bus.in_rs1 = 0; bus.in_funct3 = 0;
    bus.in_is_branch = 0; bus.in_is_jal = 0; bus.in_is_jalr = 0; bus.in_pred_taken = 0;
    bus.cmp_beq = 0; bus.cmp_blt = 0; bus.out_ready = 0; bus.flush = 0; bus.pred_pc = 0;
    model_reset();

    #12;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_taken", bus.out_taken, 1'b0);
    chk32("rst_out_target", bus.out_target, 32'h0);
    chk1("rst_out_mispredict", bus.out_mispredict, 1'b0);
    chk1("rst_out_illegal", bus.out_illegal, 1'b0);
    chk32("rst_br_count", {16'b0, bus.br_count}, 32'h0);
    chk32("rst_mp_count", {16'b0, bus.mp_count}, 32'h0);
    chk1("rst_pred_taken", bus.pred_taken, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, predicted not-taken.
    drive(1, 32'h100, 32'h20, 0, F3_BEQ, 1, 0, 0, 0, 1, 0, 1, 0, 32'h100);
    // BLTU not taken.
    drive(1, 32'h100, 32'h8, 0, F3_BLTU, 1, 0, 0, 0, 0, 0, 1, 0, 32'h100);
    chk1("bltu_cmp_un", bus.cmp_un, 1'b1);
    // JALR clears target LSB; must not train the BHT.
    drive(1, 32'h48, 32'h4, 32'h2003, 3'b000, 0, 0, 1, 0, 0, 0, 1, 0, 32'h48);
    idle(1);
    chk1("jalr_bht_untouched", bus.pred_taken, 1'b0);
    drive(1, 32'h48, 32'h4, 32'h2003, 3'b000, 0, 0, 1, 1, 0, 0, 1, 0, 32'h48);
    // Four taken BNEs at 0x40: counter climbs and saturates.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40, 32'h10, 0, F3_BNE, 1, 0, 0, 0, 0, 0, 1, 0, 32'h40);
      chk1("bne_train_pred", bus.pred_taken, (i == 0) ? 1'b0 : 1'b1);
    end
    idle(1);
    chk1("bne_saturated", bus.pred_taken, 1'b1);

    // Backpressure: hold, then release into back-to-back accepts.
    idle(1);
    drive(1, 32'h80, 32'h40, 0, F3_BGE, 1, 0, 0, 1, 0, 0, 0, 0, 32'h80);
    for (int i = 0; i < 3; i++) drive(1, 32'h84, 32'h8, 0, 3'b000, 0, 1, 0, 1, 0, 0, 0, 0, 32'h84);
    for (int i = 0; i < 4; i++) drive(1, 32'h84 + 32'(i * 4), 32'h8, 0, 3'b000, 0, 1, 0, 1, 0, 0, 1, 0, 32'h84);

    // Flush of a held result.
    drive(1, 32'h90, 32'h8, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h90);
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h90);
    idle(0);

    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 9) < 8);
      kind = $urandom_range(0, 9);
      br   = (kind <= 5);
      jal  = (kind == 6);
      jalr = (kind == 7);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      pc   = (kind == 9) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 255)) << 2);
      ppc  = 32'($urandom_range(0, 63)) << 2;
      drive(v, pc, $urandom, $urandom, 3'($urandom_range(0, 7)), br, jal, jalr,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ordy, fl, ppc);
    end

    // Asynchronous reset while a result is held.
    idle(1);
    drive(1, 32'h60, 32'h10, 0, F3_BEQ, 1, 0, 0, 0, 1, 0, 0, 0, 32'h60);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk1("pre_rst_full", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk32("mid_rst_br_count", {16'b0, bus.br_count}, 32'h0);
    chk32("mid_rst_mp_count", {16'b0, bus.mp_count}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reserved funct3 after reset.
    drive(1, 32'h200, 32'h10, 0, 3'b010, 1, 0, 0, 0, 1, 1, 1, 0, 32'h200);
    drive(1, 32'h204, 32'h10, 0, 3'b011, 1, 0, 0, 1, 0, 1, 1, 0, 32'h200);
    chk1("illegal_no_bht", bus.pred_taken, 1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      idle(1);
      #2;
    end
    chk32("drain_empty", 32'(q.size()), 32'h0);
    idle(1);
    chk1("final_out_valid", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
